// File: rtl/imm_gen_stage_if.sv
// Valid/ready channel bundle for imm_gen_stage: the upstream instruction side and the
// downstream decoded-entry side share one interface. The stage uses the slave view.
interface imm_gen_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_target;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_target, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_target, out_illegal
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: combinational immediate/format/target decode captured
// into a 2-entry skid buffer behind a valid/ready handshake.
module imm_gen_stage #(
   parameter int XLEN    = 32,
   parameter bit EN_RV64 = (XLEN == 64)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   imm_gen_stage_if.slave io_bus
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic [XLEN-1:0] target;
      logic            illegal;
   } entry_t;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   logic [31:0]     w_instr;
   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [XLEN-1:0] w_imm;
   fmt_e            w_fmt;
   logic            w_illegal;
   logic            w_tgt_en;
   entry_t          w_dec;
   logic            w_accept;
   logic            w_drain;

   state_e          r_state;
   logic            r_out_valid;
   logic            r_in_ready;
   entry_t          r_main;
   entry_t          r_skid;

   assign w_instr  = io_bus.in_instr;
   assign w_opcode = w_instr[6:0];
   assign w_funct3 = w_instr[14:12];

   // NOTE: every output gets a default first, so no path through the case can infer a latch.
   always_comb begin
      w_imm     = '0;
      w_fmt     = FMT_NONE;
      w_illegal = 1'b0;
      w_tgt_en  = 1'b0;
      case (w_opcode)
         OPC_LOAD, OPC_JALR, OPC_OP_IMM, OPC_MISC_MEM: begin
            w_fmt = FMT_I;
            w_imm = XLEN'($signed(w_instr[31:20]));
         end
         OPC_OP_IMM_32: begin
            if (EN_RV64) begin
               w_fmt = FMT_I;
               w_imm = XLEN'($signed(w_instr[31:20]));
            end else begin
               w_illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            w_fmt = FMT_S;
            w_imm = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
         end
         OPC_BRANCH: begin
            w_fmt    = FMT_B;
            w_tgt_en = 1'b1;
            w_imm    = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                      w_instr[11:8], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            w_fmt    = FMT_U;
            w_tgt_en = (w_opcode == OPC_AUIPC);
            w_imm    = XLEN'($signed({w_instr[31:12], 12'h000}));
         end
         OPC_JAL: begin
            w_fmt    = FMT_J;
            w_tgt_en = 1'b1;
            w_imm    = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                      w_instr[30:21], 1'b0}));
         end
         OPC_SYSTEM: begin
            // funct3=100 has no SYSTEM encoding; 101..111 are the CSR immediate forms.
            if (w_funct3 == 3'b100) begin
               w_illegal = 1'b1;
            end else if (w_funct3[2]) begin
               w_fmt = FMT_Z;
               w_imm = XLEN'(w_instr[19:15]);
            end else begin
               w_fmt = FMT_I;
               w_imm = XLEN'(w_instr[31:20]);
            end
         end
         OPC_OP: begin
         end
         OPC_OP_32: begin
            w_illegal = !EN_RV64;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   assign w_dec = '{
      instr:   w_instr,
      pc:      io_bus.in_pc,
      imm:     w_imm,
      fmt:     w_fmt,
      target:  w_tgt_en ? (io_bus.in_pc + w_imm) : '0,
      illegal: w_illegal
   };

   assign w_accept = io_bus.in_valid & r_in_ready;
   assign w_drain  = r_out_valid & io_bus.out_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         // NOTE: the data registers are reset too, because the outputs must read zero in reset.
         r_main      <= '0;
         r_skid      <= '0;
      end else if (i_flush) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_main      <= w_dec;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && !w_drain) begin
                  r_skid     <= w_dec;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_FULL;
               end else if (w_accept && w_drain) begin
                  r_main <= w_dec;
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_drain) begin
                  r_main     <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign io_bus.in_ready    = r_in_ready;
   assign io_bus.out_valid   = r_out_valid;
   assign io_bus.out_instr   = r_main.instr;
   assign io_bus.out_pc      = r_main.pc;
   assign io_bus.out_imm     = r_main.imm;
   assign io_bus.out_fmt     = r_main.fmt;
   assign io_bus.out_target  = r_main.target;
   assign io_bus.out_illegal = r_main.illegal;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Parametrised, pipelined immediate generator for the RV32IM/RV64 decode stage. Extracts and sign-extends the immediate for every base-ISA format, including CSR zimm, to XLEN bits. Classifies the format, flags illegal opcodes, and precomputes PC+imm branch/jump targets. It sits between fetch and the register-read/ALU stage, behind a valid/ready handshake with a 2-entry skid buffer.

## Interface
- XLEN, 32, datapath width. Legal values are 32 and 64.
- EN_RV64, (XLEN==64), when 1, OP-IMM-32 (0011011) and OP-32 (0111011) are legal.
- CLK  in  1  clock. Every register updates on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous kill of all buffered entries.
- IN_VALID  in  1  upstream holds an instruction.
- IN_READY  out  1  stage can accept an instruction.
- IN_INSTR  in  32  instruction word.
- IN_PC  in  XLEN  PC of IN_INSTR.
- OUT_VALID  out  1  output entry valid.
- OUT_READY  in  1  downstream accepts the entry.
- OUT_INSTR  out  32  instruction word, passed through.
- OUT_PC  out  XLEN  PC, passed through.
- OUT_IMM  out  XLEN  extended immediate.
- OUT_FMT  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- OUT_TARGET  out  XLEN  PC+IMM for B, J and AUIPC; 0 for all other formats.
- OUT_ILLEGAL  out  1  unsupported encoding.

## Operation
- Decode is combinational on IN_INSTR. The result is captured with PC and instruction into the main or skid register.
- Format decode by opcode = IN_INSTR[6:0]. "s" means replicate instr[31] up to XLEN.
  - I (LOAD, JALR, OP-IMM, MISC-MEM, OP-IMM-32): s, instr[30:20].
  - S (STORE 0100011): s, instr[30:25], instr[11:7].
  - B (BRANCH 1100011): s, instr[7], instr[30:25], instr[11:8], 0. The LSB is always 0.
  - U (LUI, AUIPC): instr[31:12], 12 zeros, sign-extended to XLEN when XLEN=64.
  - J (JAL 1101111): s, instr[19:12], instr[20], instr[30:21], 0.
  - SYSTEM (1110011), funct3[2]=1: fmt Z, IMM = zero-extended instr[19:15].
  - SYSTEM, funct3 in {000, 001, 010, 011}: fmt I, IMM = zero-extended instr[31:20] (CSR address / ecall code).
  - SYSTEM, funct3=100: illegal.
  - OP (0110011) and OP-32 when EN_RV64: fmt NONE, IMM=0, legal.
- Illegal conditions:
  - instr[1:0] != 11, or unlisted opcode, or RV64-only opcode with EN_RV64=0.
  - Response: OUT_ILLEGAL=1, fmt NONE, IMM=0, TARGET=0. The entry still flows normally.
- TARGET = (PC + IMM) mod 2^XLEN, computed before registering.
- Buffer FSM. State bits are main_v (OUT_VALID) and skid_v.
  - EMPTY (0,0): accept moves to ONE.
  - ONE (1,0):
    - accept with no drain moves to FULL; the new entry goes to the skid.
    - drain with no accept moves to EMPTY.
    - drain and accept together stay in ONE; the new entry goes to main.
  - FULL (1,1): drain moves skid to main, giving ONE. No accept is possible.
- IN_READY = !skid_v, driven directly from a flop. Accept = IN_VALID & IN_READY. Drain = OUT_VALID & OUT_READY.
- Entries leave in acceptance order. Output fields are stable while OUT_VALID=1 and OUT_READY=0.

## Timing
- Reset (RESETN low, asynchronous):
  - OUT_VALID=0, skid_v=0, IN_READY=1.
  - OUT_IMM, OUT_TARGET, OUT_PC, OUT_INSTR, OUT_FMT, OUT_ILLEGAL all 0.
  - Deassertion is sampled on the first rising edge after release.
- Latency: an accept at edge N gives OUT_VALID=1 after edge N when the stage was EMPTY, or when it was ONE with a simultaneous drain.
- Throughput: 1 instruction per cycle while OUT_READY=1.
- Backpressure: the first stalled cycle absorbs one extra entry in the skid. IN_READY falls the cycle after, never combinationally from OUT_READY.
- FLUSH=1 at an edge has top priority:
  - main_v and skid_v clear, and any same-cycle accept is discarded.
  - Next cycle: OUT_VALID=0, IN_READY=1.
  - Data registers need not clear.
- FLUSH during reset has no effect. Reset dominates.

## Test plan
- Format sweep, XLEN=32, OUT_READY=1. Required, each one cycle after accept:
  - ADDI x1,x0,-1 (0xFFF00093) -> IMM=0xFFFFFFFF, fmt I.
  - SW (0xFE112E23) -> IMM=0xFFFFFFFC, fmt S.
  - BEQ -4 (0xFE000EE3) at PC=0x100 -> IMM=0xFFFFFFFC, TARGET=0x0FC, fmt B.
  - JAL +2048 (0x0010006F) at PC=0 -> IMM=0x800, TARGET=0x800.
- LUI 0x80000 (0x800000B7) with XLEN=64 -> IMM=0xFFFFFFFF80000000. The same encoding with XLEN=32 -> 0x80000000.
- CSRRWI zimm=31 (0x340FD073) -> fmt Z, IMM=31. Instruction 0x00000000 -> OUT_ILLEGAL=1, IMM=0, fmt NONE.
- Backpressure and order:
  - Stream 4 instructions; hold OUT_READY=0 for 3 cycles.
  - Required: exactly 2 accepted, IN_READY=0 from the cycle after the second accept.
  - After OUT_READY=1: all 4 emerge in order with no loss or duplication.
- FLUSH in FULL state with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, and the flushed and presented instructions never appear.
- Async reset mid-stream:
  - Assert RESETN=0 between edges while FULL.
  - Required: OUT_VALID=0, IN_READY=1 and all outputs zero immediately, without waiting for an edge.
